// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the Sargantana instruction-cache refill path.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_N_WAY   = 4;
  localparam int unsigned ICACHE_IDX_W   = 6;
  localparam int unsigned ICACHE_TAG_W   = 20;
  localparam int unsigned ICACHE_BEAT_W  = 64;
  localparam int unsigned ICACHE_N_BEATS = 2;
  localparam int unsigned ICACHE_LINE_W  = ICACHE_BEAT_W * ICACHE_N_BEATS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } refill_state_t;

  typedef struct packed {
    logic                                 valid;
    logic [ICACHE_TAG_W+ICACHE_IDX_W-1:0] addr;
  } l2_req_t;

  typedef struct packed {
    logic                     valid;
    logic [ICACHE_BEAT_W-1:0] data;
    logic                     err;
  } l2_rsp_t;

endpackage

// File: rtl/sargantana_icache_line_buffer.sv
// Beat counter plus beat-indexed line register; the line itself carries no reset.
module sargantana_icache_line_buffer
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned BEAT_W  = ICACHE_BEAT_W,
  parameter int unsigned N_BEATS = ICACHE_N_BEATS
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      beat_valid_i,
  input  logic [BEAT_W-1:0]         beat_i,
  output logic                      last_o,
  output logic [BEAT_W*N_BEATS-1:0] line_o
);

  localparam int unsigned CNT_W = $clog2(N_BEATS);

  logic [CNT_W-1:0]          cnt_d, cnt_q;
  logic [BEAT_W*N_BEATS-1:0] line_d, line_q;

  // Next counter and line contents; N_BEATS is a power of two so the counter wraps naturally.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (beat_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    for (int i = 0; i < N_BEATS; i++) begin
      if (beat_valid_i && !clr_i && (cnt_q == CNT_W'(i))) begin
        line_d[i*BEAT_W +: BEAT_W] = beat_i;
      end else begin
        line_d[i*BEAT_W +: BEAT_W] = line_q[i*BEAT_W +: BEAT_W];
      end
    end
  end

  // Beat counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Line storage register.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
  end

  assign last_o = (cnt_q == CNT_W'(N_BEATS - 1));
  assign line_o = line_q;

endmodule

// File: rtl/sargantana_icache_refill_ctrl_chk.sv
// Protocol checks on the refill controller boundary: no miss while busy, no stray L2 beats.
module sargantana_icache_refill_ctrl_chk (
  input logic clk_i,
  input logic rstn_i,
  input logic miss_i,
  input logic busy_o,
  input logic l2_req_valid_o,
  input logic l2_rsp_valid_i
);

  a_no_miss_while_busy: assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(miss_i && busy_o));

  a_no_beat_outside_fill: assert property (
    @(posedge clk_i) disable iff (!rstn_i) !(l2_rsp_valid_i && (!busy_o || l2_req_valid_o)));

endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// I-cache miss/refill controller: requests a line from L2, assembles its beats and
// issues one array write, or aborts cleanly on flush or L2 error.
module sargantana_icache_refill_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_WAY   = ICACHE_N_WAY,
  parameter int unsigned IDX_W   = ICACHE_IDX_W,
  parameter int unsigned TAG_W   = ICACHE_TAG_W,
  parameter int unsigned BEAT_W  = ICACHE_BEAT_W,
  parameter int unsigned N_BEATS = ICACHE_N_BEATS,
  parameter int unsigned WAY_W   = $clog2(N_WAY),
  parameter int unsigned LINE_W  = BEAT_W * N_BEATS
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   miss_i,
  input  logic [IDX_W-1:0]       miss_idx_i,
  input  logic [TAG_W-1:0]       miss_tag_i,
  input  logic [WAY_W-1:0]       victim_way_i,
  output logic                   busy_o,
  output logic                   l2_req_valid_o,
  input  logic                   l2_req_ready_i,
  output logic [TAG_W+IDX_W-1:0] l2_req_addr_o,
  input  logic                   l2_rsp_valid_i,
  input  logic [BEAT_W-1:0]      l2_rsp_data_i,
  input  logic                   l2_rsp_err_i,
  output logic                   wr_ena_o,
  output logic [WAY_W-1:0]       wr_way_o,
  output logic [IDX_W-1:0]       wr_idx_o,
  output logic [TAG_W-1:0]       wr_tag_o,
  output logic [LINE_W-1:0]      wr_line_o,
  output logic                   done_o,
  output logic                   err_o
);

  refill_state_t    state_d, state_q;
  logic [WAY_W-1:0] way_d, way_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             beat_err_d, beat_err_q;
  logic             done_d, done_q;
  logic             done_err_d, done_err_q;

  l2_req_t          req_s;
  l2_rsp_t          rsp_s;
  logic             clr_s;
  logic             beat_valid_s;
  logic             last_s;
  logic [LINE_W-1:0] line_s;

  assign rsp_s = '{valid: l2_rsp_valid_i, data: l2_rsp_data_i, err: l2_rsp_err_i};
  assign beat_valid_s = rsp_s.valid && ((state_q == FILL) || (state_q == DRAIN));

  // Refill FSM: done_q/done_err_q flag completions that end outside WRITE.
  always_comb begin
    state_d    = state_q;
    way_d      = way_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    beat_err_d = beat_err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    clr_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_i && !flush_i) begin
          way_d      = victim_way_i;
          idx_d      = miss_idx_i;
          tag_d      = miss_tag_i;
          beat_err_d = 1'b0;
          clr_s      = 1'b1;
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (flush_i) begin
          if (l2_req_ready_i) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (l2_req_ready_i) begin
          state_d = FILL;
        end else begin
          state_d = REQ;
        end
      end
      FILL: begin
        if (rsp_s.valid) begin
          beat_err_d = beat_err_q | rsp_s.err;
          if (last_s) begin
            if (flush_i) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (beat_err_q || rsp_s.err) begin
              state_d    = IDLE;
              done_d     = 1'b1;
              done_err_d = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end else if (flush_i) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (rsp_s.valid && last_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, latched miss record and completion flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      way_q      <= {WAY_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      tag_q      <= {TAG_W{1'b0}};
      beat_err_q <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      beat_err_q <= beat_err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  sargantana_icache_line_buffer #(
    .BEAT_W  (BEAT_W),
    .N_BEATS (N_BEATS)
  ) u_line_buffer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (clr_s),
    .beat_valid_i (beat_valid_s),
    .beat_i       (rsp_s.data),
    .last_o       (last_s),
    .line_o       (line_s)
  );

  assign req_s = '{valid: (state_q == REQ), addr: {tag_q, idx_q}};

  assign busy_o         = (state_q != IDLE);
  assign l2_req_valid_o = req_s.valid;
  assign l2_req_addr_o  = req_s.addr;
  // A flush arriving in the WRITE cycle still suppresses the array write.
  assign wr_ena_o       = (state_q == WRITE) && !flush_i;
  assign wr_way_o       = way_q;
  assign wr_idx_o       = idx_q;
  assign wr_tag_o       = tag_q;
  assign wr_line_o      = wr_ena_o ? line_s : {LINE_W{1'b0}};
  assign done_o         = (state_q == WRITE) || done_q;
  assign err_o          = done_err_q;

endmodule
